// File: rtl/jtkicker_romarb_if.sv
// jtkicker_romarb_if: ROM slot requests and SDRAM read channel of the ROM arbiter.
interface jtkicker_romarb_if #(parameter int AW = 22);
  logic             downloading;
  logic [3:0]       slot_cs;
  logic [4*AW-1:0]  slot_addr;
  logic [3:0]       slot_ok;
  logic [63:0]      slot_dout;
  logic             sdram_req;
  logic             sdram_ack;
  logic [AW-1:0]    sdram_addr;
  logic             data_rdy;
  logic [15:0]      data_read;
  modport master (
    input  downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_ok, slot_dout, sdram_req, sdram_addr
  );
  modport slave (
    output downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_dout, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtkicker_romarb.sv
// jtkicker_romarb: four one-entry ROM caches sharing one SDRAM read port, round-robin refill.
module jtkicker_romarb #(
  parameter int AW    = 22,
  parameter int SLOTS = 4
) (
  input logic               clk,
  input logic               rst,
  jtkicker_romarb_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;
  state_t                      state_q, state_d;
  logic [1:0]                  ptr_q, ptr_d, g_q, g_d, sel;
  logic                        req_q, req_d, found, done;
  logic [AW-1:0]               addr_q, addr_d;
  logic [SLOTS-1:0]            valid_q, valid_d, hit, need;
  logic [SLOTS-1:0][AW-1:0]    tag_q, tag_d;
  logic [SLOTS-1:0][15:0]      data_q, data_d;
  always_comb begin
    hit = '0;
    for (int n = 0; n < SLOTS; n++) hit[n] = valid_q[n] && tag_q[n] == bus.slot_addr[n*AW +: AW];
  end
  assign need           = bus.slot_cs & ~hit;
  assign bus.slot_ok    = bus.slot_cs & hit & {SLOTS{~bus.downloading}};
  assign bus.slot_dout  = data_q;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;
  // search starts just after the last served slot, wrapping back to it last
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    for (int i = 1; i <= SLOTS; i++) begin
      if (!found && need[2'(ptr_q + 2'(i))]) begin
        sel   = 2'(ptr_q + 2'(i));
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    done    = 1'b0;
    if (bus.downloading) begin
      state_d = IDLE;
      req_d   = 1'b0;
      valid_d = '0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          g_d     = sel;
          addr_d  = bus.slot_addr[sel*AW +: AW];
          req_d   = 1'b1;
          state_d = WAIT_ACK;
        end
        WAIT_ACK: if (bus.sdram_ack) begin
          req_d   = 1'b0;
          done    = bus.data_rdy;
          state_d = bus.data_rdy ? IDLE : WAIT_DATA;
        end
        WAIT_DATA: if (bus.data_rdy) begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (done) begin
        data_d[g_q]  = bus.data_read;
        tag_d[g_q]   = addr_q;
        valid_d[g_q] = 1'b1;
        ptr_d        = g_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      g_q     <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_jtkicker_romarb.sv
// tb_jtkicker_romarb: per-cycle directed vectors for the ROM arbiter plus a grant-spacing sequence.
module tb_jtkicker_romarb;
  localparam int AW = 22;
  typedef struct {
    logic                 r, dl;
    logic [3:0]           cs;
    logic [3:0][AW-1:0]   a;
    logic                 ack, rdy;
    logic [15:0]          dat;
    logic                 e_req;
    logic [AW-1:0]        e_addr;
    logic [3:0]           e_ok;
    logic [63:0]          e_dout;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  vec_t tbl[$];
  logic [3:0][AW-1:0] ca;
  jtkicker_romarb_if #(.AW(AW)) bus();
  jtkicker_romarb #(.AW(AW), .SLOTS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic void v(logic r, logic dl, logic [3:0] cs, logic ack, logic rdy, logic [15:0] dat,
                            logic er, logic [AW-1:0] ea, logic [3:0] eo, logic [63:0] ed);
    vec_t t;
    t.r = r; t.dl = dl; t.cs = cs; t.a = ca; t.ack = ack; t.rdy = rdy; t.dat = dat;
    t.e_req = er; t.e_addr = ea; t.e_ok = eo; t.e_dout = ed;
    tbl.push_back(t);
  endfunction
  task automatic chk(string nm, int i, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", nm, i, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    bus.downloading = 1'b0;
    bus.slot_cs     = '0;
    bus.slot_addr   = '0;
    bus.sdram_ack   = 1'b0;
    bus.data_rdy    = 1'b0;
    bus.data_read   = '0;
    ca = '0;
    // single fetch, then no further request while the address is unchanged
    v(1,0,4'h0,0,0,0,      0,0,4'h0,0);
    ca[0] = 22'h123;
    v(0,0,4'h1,0,0,0,      1,22'h123,4'h0,0);
    v(0,0,4'h1,0,0,0,      1,22'h123,4'h0,0);
    v(0,0,4'h1,1,0,0,      0,22'h123,4'h0,0);
    v(0,0,4'h1,0,0,0,      0,22'h123,4'h0,0);
    v(0,0,4'h1,0,0,0,      0,22'h123,4'h0,0);
    v(0,0,4'h1,0,1,16'hBEEF, 0,22'h123,4'h1,64'hBEEF);
    v(0,0,4'h1,0,0,0,      0,22'h123,4'h1,64'hBEEF);
    v(0,0,4'h1,0,0,0,      0,22'h123,4'h1,64'hBEEF);
    // round robin over four slots, then slots 0 and 2 refetch with ptr=3
    ca = '0;
    v(1,0,4'h0,0,0,0,      0,0,4'h0,0);
    ca = {22'h103, 22'h102, 22'h101, 22'h100};
    v(0,0,4'hF,0,0,0,      1,22'h100,4'h0,0);
    v(0,0,4'hF,1,0,0,      0,22'h100,4'h0,0);
    v(0,0,4'hF,0,1,16'hA000, 0,22'h100,4'h1,64'hA000);
    v(0,0,4'hF,0,0,0,      1,22'h101,4'h1,64'hA000);
    v(0,0,4'hF,1,0,0,      0,22'h101,4'h1,64'hA000);
    v(0,0,4'hF,0,1,16'hA001, 0,22'h101,4'h3,64'hA001_A000);
    v(0,0,4'hF,0,0,0,      1,22'h102,4'h3,64'hA001_A000);
    v(0,0,4'hF,1,0,0,      0,22'h102,4'h3,64'hA001_A000);
    v(0,0,4'hF,0,1,16'hA002, 0,22'h102,4'h7,64'hA002_A001_A000);
    v(0,0,4'hF,0,0,0,      1,22'h103,4'h7,64'hA002_A001_A000);
    v(0,0,4'hF,1,0,0,      0,22'h103,4'h7,64'hA002_A001_A000);
    v(0,0,4'hF,0,1,16'hA003, 0,22'h103,4'hF,64'hA003_A002_A001_A000);
    ca[0] = 22'h200;
    ca[2] = 22'h202;
    v(0,0,4'hF,0,0,0,      1,22'h200,4'hA,64'hA003_A002_A001_A000);
    v(0,0,4'hF,1,1,16'hB000, 0,22'h200,4'hB,64'hA003_A002_A001_B000);
    v(0,0,4'hF,0,0,0,      1,22'h202,4'hB,64'hA003_A002_A001_B000);
    v(0,0,4'hF,1,0,0,      0,22'h202,4'hB,64'hA003_A002_A001_B000);
    v(0,0,4'hF,0,1,16'hB002, 0,22'h202,4'hF,64'hA003_B002_A001_B000);
    v(0,0,4'hF,0,0,0,      0,22'h202,4'hF,64'hA003_B002_A001_B000);
    v(0,1,4'hF,0,0,0,      0,22'h202,4'h0,64'hA003_B002_A001_B000);
    v(0,0,4'hF,0,0,0,      1,22'h103,4'h0,64'hA003_B002_A001_B000);
    // address change while waiting for data
    ca = '0;
    v(1,0,4'h0,0,0,0,      0,0,4'h0,0);
    ca[1] = 22'h10;
    v(0,0,4'h2,0,0,0,      1,22'h10,4'h0,0);
    v(0,0,4'h2,1,0,0,      0,22'h10,4'h0,0);
    ca[1] = 22'h20;
    v(0,0,4'h2,0,0,0,      0,22'h10,4'h0,0);
    v(0,0,4'h2,0,1,16'h1111, 0,22'h10,4'h0,64'h1111_0000);
    v(0,0,4'h2,0,0,0,      1,22'h20,4'h0,64'h1111_0000);
    v(0,0,4'h2,1,0,0,      0,22'h20,4'h0,64'h1111_0000);
    v(0,0,4'h2,0,1,16'h2222, 0,22'h20,4'h2,64'h2222_0000);
    // download abort in WAIT_DATA; data_rdy during and after is dropped
    ca = '0;
    v(1,0,4'h0,0,0,0,      0,0,4'h0,0);
    ca[0] = 22'h55;
    v(0,0,4'h1,0,0,0,      1,22'h55,4'h0,0);
    v(0,0,4'h1,1,0,0,      0,22'h55,4'h0,0);
    v(0,1,4'h1,0,0,0,      0,22'h55,4'h0,0);
    v(0,1,4'h1,0,1,16'hDEAD, 0,22'h55,4'h0,0);
    v(0,0,4'h1,0,1,16'hDEAD, 1,22'h55,4'h0,0);
    v(0,0,4'h1,1,1,16'h7777, 0,22'h55,4'h1,64'h7777);
    // reset in WAIT_ACK
    ca = '0;
    v(1,0,4'h0,0,0,0,      0,0,4'h0,0);
    ca[0] = 22'h77;
    v(0,0,4'h1,0,0,0,      1,22'h77,4'h0,0);
    v(1,0,4'h1,0,0,0,      0,0,4'h0,0);
    v(0,0,4'h1,0,1,16'h9999, 1,22'h77,4'h0,0);
    v(0,0,4'h1,1,1,16'h4444, 0,22'h77,4'h1,64'h4444);
    for (int i = 0; i < tbl.size(); i++) begin
      rst             = tbl[i].r;
      bus.downloading = tbl[i].dl;
      bus.slot_cs     = tbl[i].cs;
      bus.slot_addr   = tbl[i].a;
      bus.sdram_ack   = tbl[i].ack;
      bus.data_rdy    = tbl[i].rdy;
      bus.data_read   = tbl[i].dat;
      step();
      chk("sdram_req",  i, 64'(bus.sdram_req),  64'(tbl[i].e_req));
      chk("sdram_addr", i, 64'(bus.sdram_addr), 64'(tbl[i].e_addr));
      chk("slot_ok",    i, 64'(bus.slot_ok),    64'(tbl[i].e_ok));
      chk("slot_dout",  i, bus.slot_dout,       tbl[i].e_dout);
    end
    // spacing between a completion and the next grant
    rst = 1'b1; bus.slot_cs = '0; bus.sdram_ack = 1'b0; bus.data_rdy = 1'b0; bus.downloading = 1'b0;
    step();
    rst = 1'b0;
    ca = '0;
    ca[0] = 22'h300;
    ca[1] = 22'h301;
    bus.slot_addr = ca;
    bus.slot_cs   = 4'h3;
    n = 0;
    do begin step(); n++; end while (!bus.sdram_req && n < 10);
    chk("first_req_latency", 0, 64'(n), 64'd1);
    chk("first_req_addr",    0, 64'(bus.sdram_addr), 64'h300);
    bus.sdram_ack = 1'b1; bus.data_rdy = 1'b1; bus.data_read = 16'h5A5A;
    step();
    bus.sdram_ack = 1'b0; bus.data_rdy = 1'b0;
    chk("req_after_done", 0, 64'(bus.sdram_req), 64'd0);
    chk("ok_after_done",  0, 64'(bus.slot_ok),   64'h1);
    n = 1;
    while (!bus.sdram_req && n < 10) begin step(); n++; end
    chk("grant_gap",      0, 64'(n), 64'd2);
    chk("second_req_addr",0, 64'(bus.sdram_addr), 64'h301);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
